// File: rtl/mux_gamma_scheduler.sv
// Shares one column between two networks per gamma (A run, gap, B run, gap) and drives a ping-pong replay buffer.
// Latency: control outputs decode the current state; spike results register one clk after a phase's last clock.
// No backpressure: grst paces the block; an early gamma edge aborts and sets sticky overrun. Option: MUX_SPIKE_TIME_EN.
module mux_gamma_scheduler #(
  parameter int Q         = 2,
  parameter int PHASE_LEN = 8,
  parameter int GAP_LEN   = 1,
  localparam int AW       = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1,
  localparam int TW       = $clog2(PHASE_LEN + 1),
  localparam int PERIOD   = 2 * (PHASE_LEN + GAP_LEN),
  localparam int CW       = $clog2(PERIOD)
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 grst,
  input  logic [Q-1:0]         col_spikes,
  output logic                 wr_en,
  output logic                 wr_bank,
  output logic [AW-1:0]        wr_addr,
  output logic                 rd_bank,
  output logic                 rd_net,
  output logic [AW-1:0]        rd_addr,
  output logic                 col_rst,
  output logic [Q-1:0]         output_spikes1,
  output logic [Q-1:0]         output_spikes2,
  output logic                 valid1,
  output logic                 valid2,
`ifdef MUX_SPIKE_TIME_EN
  output logic [Q-1:0][TW-1:0] spike_time1,
  output logic [Q-1:0][TW-1:0] spike_time2,
`endif
  output logic                 overrun
);

  typedef enum logic [2:0] {IDLE, RUN_A, GAP_A, RUN_B, GAP_B} state_t;

  localparam logic [CW-1:0] A_LAST  = CW'(PHASE_LEN - 1);
  localparam logic [CW-1:0] GA_LAST = CW'(PHASE_LEN + GAP_LEN - 1);
  localparam logic [CW-1:0] B_BASE  = CW'(PHASE_LEN + GAP_LEN);
  localparam logic [CW-1:0] B_LAST  = CW'(2 * PHASE_LEN + GAP_LEN - 1);
  localparam logic [CW-1:0] G_LAST  = CW'(PERIOD - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          grst_d;
  logic          start;
  logic          primed;
  logic [Q-1:0]  acc;
  logic          acc_en;
  logic          pub_a;
  logic          pub_b;
  logic          abort;
  logic          set_primed;
  logic [AW-1:0] slot;

  assign start   = grst & ~grst_d;
  assign rd_bank = ~wr_bank;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    col_rst    = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    rd_net     = 1'b0;
    rd_addr    = '0;
    slot       = '0;
    acc_en     = 1'b0;
    pub_a      = 1'b0;
    pub_b      = 1'b0;
    abort      = 1'b0;
    set_primed = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
      end
      RUN_A: begin
        slot    = cnt[AW-1:0];
        col_rst = 1'b0;
        wr_en   = 1'b1;
        wr_addr = slot;
        rd_addr = slot;
        acc_en  = 1'b1;
        cnt_nxt = cnt + CW'(1);
        if (cnt == A_LAST) begin
          pub_a     = 1'b1;
          state_nxt = GAP_A;
        end
      end
      GAP_A: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == GA_LAST) state_nxt = RUN_B;
      end
      RUN_B: begin
        slot    = AW'(cnt - B_BASE);
        col_rst = 1'b0;
        rd_net  = 1'b1;
        rd_addr = slot;
        acc_en  = 1'b1;
        cnt_nxt = cnt + CW'(1);
        if (cnt == B_LAST) begin
          pub_b     = 1'b1;
          state_nxt = GAP_B;
        end
      end
      GAP_B: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == G_LAST) begin
          set_primed = 1'b1;
          state_nxt  = IDLE;
          cnt_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // A gamma edge always restarts phase A; it is only an error if the schedule had not finished.
    if (start) begin
      if (state != IDLE && !(state == GAP_B && cnt == G_LAST)) abort = 1'b1;
      pub_a     = 1'b0;
      pub_b     = 1'b0;
      state_nxt = RUN_A;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      grst_d         <= 1'b0;
      wr_bank        <= 1'b0;
      primed         <= 1'b0;
      overrun        <= 1'b0;
      acc            <= '0;
      output_spikes1 <= '0;
      output_spikes2 <= '0;
      valid1         <= 1'b0;
      valid2         <= 1'b0;
    end else begin
      grst_d <= grst;
      valid1 <= 1'b0;
      valid2 <= 1'b0;
      if (start) wr_bank <= ~wr_bank;
      if (abort) overrun <= 1'b1;
      if (set_primed) primed <= 1'b1;
      if (start || pub_a || pub_b) acc <= '0;
      else if (acc_en) acc <= acc | col_spikes;
      // The last phase sample is folded in directly so the result lands on the first gap clock.
      if (pub_a) begin
        output_spikes1 <= acc | col_spikes;
        valid1         <= primed;
      end
      if (pub_b) begin
        output_spikes2 <= acc | col_spikes;
        valid2         <= primed;
      end
    end
  end

`ifdef MUX_SPIKE_TIME_EN
  logic [Q-1:0][TW-1:0] t_acc, t_nxt;

  // PHASE_LEN doubles as "no spike yet", so only the first spike in a phase is latched.
  always_comb begin
    t_nxt = t_acc;
    for (int i = 0; i < Q; i++) begin
      if (col_spikes[i] && t_acc[i] == TW'(PHASE_LEN)) t_nxt[i] = TW'(slot);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      t_acc       <= {Q{TW'(PHASE_LEN)}};
      spike_time1 <= '0;
      spike_time2 <= '0;
    end else begin
      if (start || pub_a || pub_b) t_acc <= {Q{TW'(PHASE_LEN)}};
      else if (acc_en) t_acc <= t_nxt;
      if (pub_a) spike_time1 <= t_nxt;
      if (pub_b) spike_time2 <= t_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mux_gamma_scheduler.sv
// Bench for mux_gamma_scheduler: directed and random gamma periods checked each clock against a
// schedule-position reference model (gamma position counter plus per-gamma sample history).
module tb_mux_gamma_scheduler;
  localparam int Q      = 2;
  localparam int PL     = 8;
  localparam int GL     = 1;
  localparam int PERIOD = 2 * (PL + GL);
  localparam int AW     = $clog2(PL);
  localparam int TW     = $clog2(PL + 1);

  logic                 clk = 1'b0;
  logic                 rstb = 1'b1;
  logic                 grst = 1'b0;
  logic [Q-1:0]         col_spikes = '0;
  logic                 wr_en, wr_bank, rd_bank, rd_net, col_rst;
  logic [AW-1:0]        wr_addr, rd_addr;
  logic [Q-1:0]         output_spikes1, output_spikes2;
  logic                 valid1, valid2, overrun;
`ifdef MUX_SPIKE_TIME_EN
  logic [Q-1:0][TW-1:0] spike_time1, spike_time2;
`endif

  mux_gamma_scheduler #(.Q(Q), .PHASE_LEN(PL), .GAP_LEN(GL)) dut (
    .clk(clk), .rstb(rstb), .grst(grst), .col_spikes(col_spikes),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .rd_bank(rd_bank), .rd_net(rd_net), .rd_addr(rd_addr),
    .col_rst(col_rst), .output_spikes1(output_spikes1), .output_spikes2(output_spikes2),
    .valid1(valid1), .valid2(valid2),
`ifdef MUX_SPIKE_TIME_EN
    .spike_time1(spike_time1), .spike_time2(spike_time2),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int v1_cnt = 0;
  int v2_cnt = 0;

  // Reference model: pos is the clock index within the gamma (-1 when idle).
  int           pos;
  bit           m_grst_d, m_wr_bank, m_primed, m_overrun, m_v1, m_v2;
  logic [Q-1:0] m_out1, m_out2;
  logic [Q-1:0] samp [PERIOD];
  int           m_t1 [Q];
  int           m_t2 [Q];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pos = -1;
    m_grst_d = 0; m_wr_bank = 0; m_primed = 0; m_overrun = 0; m_v1 = 0; m_v2 = 0;
    m_out1 = '0; m_out2 = '0;
    for (int j = 0; j < PERIOD; j++) samp[j] = '0;
    for (int i = 0; i < Q; i++) begin m_t1[i] = 0; m_t2[i] = 0; end
  endtask

  // OR of one phase's samples and the first-spike offset of each neuron.
  task automatic phase_result(input int base, output logic [Q-1:0] o, output int t [Q]);
    o = '0;
    for (int i = 0; i < Q; i++) t[i] = PL;
    for (int j = 0; j < PL; j++) begin
      o = o | samp[base + j];
      for (int i = 0; i < Q; i++)
        if (samp[base + j][i] && t[i] == PL) t[i] = j;
    end
  endtask

  task automatic advance(input logic g, input logic [Q-1:0] cs);
    bit st, last;
    st = g && !m_grst_d;
    last = (pos == PERIOD - 1);
    m_v1 = 0; m_v2 = 0;
    if (pos >= 0) samp[pos] = cs;
    if (st && pos >= 0 && !last) begin
      m_overrun = 1;
    end else begin
      if (pos == PL - 1) begin phase_result(0, m_out1, m_t1); m_v1 = m_primed; end
      if (pos == 2 * PL + GL - 1) begin phase_result(PL + GL, m_out2, m_t2); m_v2 = m_primed; end
      if (last) m_primed = 1;
    end
    if (st) begin
      pos = 0;
      m_wr_bank = !m_wr_bank;
      for (int j = 0; j < PERIOD; j++) samp[j] = '0;
    end else if (pos >= 0) begin
      pos = last ? -1 : pos + 1;
    end
    m_grst_d = g;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_col_rst"}, col_rst, 1);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_bank"}, wr_bank, 0);
    chk({tag, "_rd_bank"}, rd_bank, 1);
    chk({tag, "_rd_net"}, rd_net, 0);
    chk({tag, "_addrs"}, {wr_addr, rd_addr}, 0);
    chk({tag, "_spikes"}, {output_spikes1, output_spikes2}, 0);
    chk({tag, "_valids"}, {valid1, valid2}, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic check_all();
    bit ra, rb;
    logic [31:0] e1, e2;
    ra = (pos >= 0 && pos < PL);
    rb = (pos >= PL + GL && pos < 2 * PL + GL);
    chk("col_rst", col_rst, !(ra || rb));
    chk("wr_en", wr_en, ra);
    chk("wr_bank", wr_bank, m_wr_bank);
    chk("rd_bank", rd_bank, !m_wr_bank);
    chk("overrun", overrun, m_overrun);
    chk("out1", output_spikes1, m_out1);
    chk("out2", output_spikes2, m_out2);
    chk("valid1", valid1, m_v1);
    chk("valid2", valid2, m_v2);
    if (ra) begin
      chk("wr_addr", wr_addr, pos);
      chk("rd_addr_a", rd_addr, pos);
      chk("rd_net_a", rd_net, 0);
    end
    if (rb) begin
      chk("rd_addr_b", rd_addr, pos - (PL + GL));
      chk("rd_net_b", rd_net, 1);
    end
    e1 = '0; e2 = '0;
`ifdef MUX_SPIKE_TIME_EN
    for (int i = 0; i < Q; i++) begin
      e1[i*TW +: TW] = TW'(m_t1[i]);
      e2[i*TW +: TW] = TW'(m_t2[i]);
    end
    chk("spike_time1", 32'(spike_time1), e1);
    chk("spike_time2", 32'(spike_time2), e2);
`endif
    v1_cnt += int'(valid1);
    v2_cnt += int'(valid2);
  endtask

  // One gamma: grst high for 4 clocks then low. rnd=0 uses the directed spike pattern.
  task automatic run_gamma(input int period, input bit rnd, input int rst_k);
    for (int k = 0; k < period; k++) begin
      @(negedge clk);
      check_all();
      grst = (k < 4);
      if (rnd) col_spikes = Q'($urandom);
      else col_spikes = (pos == 3) ? Q'(1) : (pos == PL + GL + 5) ? Q'(2) : Q'(0);
      advance(grst, col_spikes);
      if (k == rst_k) begin
        #2 rstb = 1'b0;
        grst = 1'b0;
        col_spikes = '0;
        #1 chk_reset("midrst");
        model_reset();
        return;
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    chk_reset("rst_hold");
    rstb = 1'b1;
    advance(1'b0, '0);
  endtask

  initial begin
    model_reset();
    #1 rstb = 1'b0;
    release_reset();

    // Directed: two 18-clock gammas, then a 30-clock gamma with 12 idle clocks.
    run_gamma(18, 0, -1);
    run_gamma(18, 0, -1);
    chk("g01_valid1_cnt", v1_cnt, 1);
    chk("g01_valid2_cnt", v2_cnt, 0);
    run_gamma(30, 0, -1);
    chk("g2_valid1_cnt", v1_cnt, 2);
    chk("g2_valid2_cnt", v2_cnt, 2);
    chk("g2_out1", output_spikes1, 2'b01);
    chk("g2_out2", output_spikes2, 2'b10);
    chk("g2_no_overrun", overrun, 0);
    chk("g2_idle_col_rst", col_rst, 1);

    // Early gamma edge 12 clocks after the previous one.
    run_gamma(18, 0, -1);
    run_gamma(12, 0, -1);
    run_gamma(18, 0, -1);
    chk("early_overrun", overrun, 1);

    for (int n = 0; n < 25; n++) run_gamma($urandom_range(10, 32), 1, -1);

    // Reset in the middle of phase B, then the next gamma is unprimed again.
    model_reset();
    rstb = 1'b0;
    release_reset();
    run_gamma(18, 0, 13);
    release_reset();
    v1_cnt = 0;
    v2_cnt = 0;
    run_gamma(18, 0, -1);
    run_gamma(18, 0, -1);
    chk("post_rst_valid1_cnt", v1_cnt, 1);
    chk("post_rst_valid2_cnt", v2_cnt, 0);
    run_gamma(20, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
